// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// hazard_pkg : opcode constants and scoreboard entry layout for hazard_scoreboard
// Revision   : 1.0
// ============================================================================
package hazard_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       is_load;
    } sb_entry_t;

    // $0 is hardwired, so an entry targeting it never produces a hazard.
    function automatic logic sb_writer(input sb_entry_t e);
        return e.valid && (e.dest != 5'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_decode.sv
`default_nettype none
// ============================================================================
// hazard_decode : combinational register-usage decode of a MIPS instruction
// Revision      : 1.0
// ============================================================================
module hazard_decode
    import hazard_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic        rs_used,
    output logic        rt_used,
    output logic        writes,
    output logic [4:0]  dest,
    output logic        is_load,
    output logic        is_branch
);

    logic [5:0] w_op;
    logic       w_unused;

    assign w_op     = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign w_unused = ^instr[10:0];

    always_comb begin
        rs_used   = 1'b0;
        rt_used   = 1'b0;
        writes    = 1'b0;
        dest      = 5'd0;
        is_load   = 1'b0;
        is_branch = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                rs_used = 1'b1;
                rt_used = 1'b1;
                writes  = 1'b1;
                dest    = instr[15:11];
            end
            OP_LW: begin
                rs_used = 1'b1;
                writes  = 1'b1;
                dest    = instr[20:16];
                is_load = 1'b1;
            end
            OP_SW: begin
                rs_used = 1'b1;
                rt_used = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                rs_used   = 1'b1;
                rt_used   = 1'b1;
                is_branch = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI: begin
                rs_used = 1'b1;
                writes  = 1'b1;
                dest    = instr[20:16];
            end
            OP_LUI: begin
                writes = 1'b1;
                dest   = instr[20:16];
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard : RAW/load-use stall detection, branch fetch hold and
//                     stall-cycle counter at the IF/ID boundary
// Revision          : 1.0
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH        = 3,
    parameter int FORWARD      = 0,
    parameter int BRANCH_SLOTS = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             stall,
    output logic             issue,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [0:0] c_RUN  = 1'b0;
    localparam logic [0:0] c_HOLD = 1'b1;

    logic [4:0] w_rs, w_rt, w_dest;
    logic       w_rs_used, w_rt_used, w_writes, w_is_load, w_is_branch;
    logic       w_hazard;
    logic [0:0] r_state, w_state_nxt;
    logic [2:0] r_bcnt, w_bcnt_nxt;
    logic [CNT_W-1:0] r_count;
    sb_entry_t  r_sb [DEPTH];
    sb_entry_t  w_new;

    hazard_decode u_decode (
        .instr     (instr),
        .rs        (w_rs),
        .rt        (w_rt),
        .rs_used   (w_rs_used),
        .rt_used   (w_rt_used),
        .writes    (w_writes),
        .dest      (w_dest),
        .is_load   (w_is_load),
        .is_branch (w_is_branch)
    );

    // With forwarding only a load in the youngest slot can still block a reader.
    always_comb begin
        w_hazard = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (sb_writer(r_sb[k]) &&
                ((w_rs_used && (w_rs == r_sb[k].dest)) ||
                 (w_rt_used && (w_rt == r_sb[k].dest)))) begin
                if ((FORWARD == 0) || ((k == 0) && r_sb[k].is_load)) begin
                    w_hazard = 1'b1;
                end
            end
        end
        w_hazard = w_hazard & instr_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_RUN;
            r_bcnt  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_bcnt  <= w_bcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        case (r_state)
            c_RUN: begin
                if (issue && w_is_branch && (BRANCH_SLOTS != 0)) begin
                    w_state_nxt = c_HOLD;
                    w_bcnt_nxt  = 3'(BRANCH_SLOTS);
                end
            end
            c_HOLD: begin
                w_bcnt_nxt = r_bcnt - 3'd1;
                if (r_bcnt == 3'd1) begin
                    w_state_nxt = c_RUN;
                end
            end
            default: w_state_nxt = c_RUN;
        endcase
    end

    always_comb begin
        stall  = w_hazard;
        issue  = instr_valid & ~w_hazard;
        bubble = ~(instr_valid & ~w_hazard);
        if (r_state == c_HOLD) begin
            stall  = 1'b1;
            issue  = 1'b0;
            bubble = 1'b1;
        end
    end

    always_comb begin
        w_new.valid   = issue;
        w_new.dest    = w_writes ? w_dest : 5'd0;
        w_new.is_load = issue & w_is_load;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_sb[k] <= '0;
            end
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_sb[k] <= r_sb[k-1];
            end
            r_sb[0] <= w_new;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (stall && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign stall_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// tb_hazard_scoreboard : directed checks on three parameterisations sharing inputs
// Revision             : 1.0
// ============================================================================
module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;

    logic        s0, i0, b0;
    logic [15:0] c0;
    logic        s1, i1, b1;
    logic [15:0] c1;
    logic        s2, i2, b2;
    logic [3:0]  c2;

    int total;
    int bad;

    hazard_scoreboard #(.DEPTH(3), .FORWARD(0), .BRANCH_SLOTS(2), .CNT_W(16)) u_dut0 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .stall(s0), .issue(i0), .bubble(b0), .stall_count(c0)
    );

    hazard_scoreboard #(.DEPTH(3), .FORWARD(1), .BRANCH_SLOTS(2), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .stall(s1), .issue(i1), .bubble(b1), .stall_count(c1)
    );

    hazard_scoreboard #(.DEPTH(3), .FORWARD(0), .BRANCH_SLOTS(2), .CNT_W(4)) u_dut2 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .stall(s2), .issue(i2), .bubble(b2), .stall_count(c2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int funct);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic es, input logic ei);
        chk({tag, "_stall"},  {31'd0, s0}, {31'd0, es});
        chk({tag, "_issue"},  {31'd0, i0}, {31'd0, ei});
        chk({tag, "_bubble"}, {31'd0, b0}, {31'd0, ~ei});
    endtask

    task automatic chk1(input string tag, input logic es, input logic ei);
        chk({tag, "_stall"},  {31'd0, s1}, {31'd0, es});
        chk({tag, "_issue"},  {31'd0, i1}, {31'd0, ei});
        chk({tag, "_bubble"}, {31'd0, b1}, {31'd0, ~ei});
    endtask

    task automatic go(input logic v, input logic [31:0] ins);
        instr_valid = v;
        instr       = ins;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (3) begin
            go(1'b0, 32'd0);
            adv();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] add3, sub4, add0, rd0, beq12, add6, add1, add9, add12, add13;
        logic [31:0] lw8, add10, add8;
        add3  = rtype(1, 2, 3, 32);
        sub4  = rtype(3, 5, 4, 34);
        add0  = rtype(1, 2, 0, 32);
        rd0   = rtype(0, 0, 5, 32);
        beq12 = itype(4, 1, 2, 3);
        add6  = rtype(7, 7, 6, 32);
        add1  = rtype(2, 3, 1, 32);
        add9  = rtype(10, 11, 9, 32);
        add12 = rtype(1, 2, 12, 32);
        add13 = rtype(12, 1, 13, 32);
        lw8   = itype(35, 9, 8, 0);
        add10 = rtype(8, 8, 10, 32);
        add8  = rtype(1, 2, 8, 32);

        total = 0;
        bad   = 0;
        clk   = 1'b0;
        reset = 1'b1;
        instr_valid = 1'b0;
        instr = 32'd0;
        adv();

        // reset values
        go(1'b1, add3);
        chk0("rst_v1", 1'b0, 1'b1);
        chk("rst_cnt0", 32'(c0), 32'd0);
        chk("rst_cnt2", 32'(c2), 32'd0);
        instr_valid = 1'b0;
        #1;
        chk0("rst_v0", 1'b0, 1'b0);
        adv();
        reset = 1'b0;

        // back-to-back RAW, DEPTH=3
        go(1'b1, add3);
        chk0("raw_prod", 1'b0, 1'b1);
        adv();
        repeat (3) begin
            go(1'b1, sub4);
            chk0("raw_stall", 1'b1, 1'b0);
            adv();
        end
        go(1'b1, sub4);
        chk0("raw_issue", 1'b0, 1'b1);
        chk("raw_cnt", 32'(c0), 32'd3);
        adv();
        go(1'b0, 32'd0);
        chk0("idle", 1'b0, 1'b0);
        adv();
        drain();

        // writer to $0
        go(1'b1, add0);
        chk0("zero_prod", 1'b0, 1'b1);
        adv();
        go(1'b1, rd0);
        chk0("zero_use", 1'b0, 1'b1);
        adv();
        drain();

        // branch without hazard
        go(1'b1, beq12);
        chk0("br_issue", 1'b0, 1'b1);
        adv();
        repeat (2) begin
            go(1'b1, add6);
            chk0("br_hold", 1'b1, 1'b0);
            adv();
        end
        go(1'b1, add6);
        chk0("br_run", 1'b0, 1'b1);
        chk("br_cnt", 32'(c0), 32'd5);
        adv();
        drain();

        // branch with hazard on $1: data stalls, then hold
        go(1'b1, add1);
        chk0("brh_prod", 1'b0, 1'b1);
        adv();
        repeat (3) begin
            go(1'b1, beq12);
            chk0("brh_data", 1'b1, 1'b0);
            adv();
        end
        go(1'b1, beq12);
        chk0("brh_issue", 1'b0, 1'b1);
        adv();
        repeat (2) begin
            go(1'b1, add9);
            chk0("brh_hold", 1'b1, 1'b0);
            adv();
        end
        go(1'b1, add9);
        chk0("brh_run", 1'b0, 1'b1);
        chk("brh_cnt", 32'(c0), 32'd10);
        adv();
        drain();

        // reset during hold with bcnt=1
        go(1'b1, beq12);
        chk0("rh_br", 1'b0, 1'b1);
        adv();
        go(1'b1, add12);
        chk0("rh_hold2", 1'b1, 1'b0);
        adv();
        go(1'b1, add12);
        chk0("rh_hold1", 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        chk0("rh_reset", 1'b0, 1'b1);
        chk("rh_cnt", 32'(c0), 32'd0);
        adv();
        reset = 1'b0;
        go(1'b1, add12);
        chk0("rh_after", 1'b0, 1'b1);
        adv();

        // reset during a data stall
        go(1'b1, add13);
        chk0("rs_stall", 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        chk0("rs_reset", 1'b0, 1'b1);
        adv();
        reset = 1'b0;
        go(1'b1, add13);
        chk0("rs_after", 1'b0, 1'b1);
        adv();
        drain();

        // forwarding: load-use and ALU producer
        reset = 1'b1;
        #1;
        reset = 1'b0;
        go(1'b1, lw8);
        chk1("lu_prod", 1'b0, 1'b1);
        adv();
        go(1'b1, add10);
        chk1("lu_stall", 1'b1, 1'b0);
        adv();
        go(1'b1, add10);
        chk1("lu_issue", 1'b0, 1'b1);
        chk("lu_cnt", 32'(c1), 32'd1);
        adv();
        drain();
        go(1'b1, add8);
        chk1("fw_prod", 1'b0, 1'b1);
        adv();
        go(1'b1, add10);
        chk1("fw_use", 1'b0, 1'b1);
        chk("fw_cnt", 32'(c1), 32'd1);
        adv();
        drain();

        // counter saturation: 7 dependent pairs, 3 stalls each
        reset = 1'b1;
        #1;
        reset = 1'b0;
        for (int p = 0; p < 7; p++) begin
            go(1'b1, add3);
            adv();
            repeat (4) begin
                go(1'b1, sub4);
                adv();
            end
            if (p == 3) begin
                go(1'b0, 32'd0);
                chk("sat_mid4", 32'(c2), 32'd12);
                chk("sat_mid16", 32'(c0), 32'd12);
                adv();
            end
        end
        go(1'b0, 32'd0);
        chk("sat_cnt4", 32'(c2), 32'd15);
        chk("sat_cnt16", 32'(c0), 32'd21);
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard-detection and stall sequencer for the pipelined MIPS CPU, sitting at the IF/ID boundary. It tracks the destination registers of the last `DEPTH` issued instructions in a shift-register scoreboard and stalls decode on read-after-write conflicts, with load-use-only checking when forwarding is enabled. It also holds fetch for a programmable number of cycles after each branch, inserts a bubble into EX on every stall cycle, and counts stall cycles for performance measurement.

## Interface
- `DEPTH`, 3: scoreboard slots, i.e. ID-to-writeback distance in issued cycles (1..7).
- `FORWARD`, 0: 0 = stall on any in-window RAW; 1 = stall only on load-use (slot 0 is a load).
- `BRANCH_SLOTS`, 2: fetch-hold cycles after a beq/bne issues (0..7).
- `CNT_W`, 16: width of the stall counter.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  `instr` holds a real instruction in ID.
- `instr`  in  32  instruction currently in ID.
- `stall`  out  1  hold PC and IF/ID register this cycle.
- `issue`  out  1  `instr` advances to EX at this edge.
- `bubble`  out  1  EX receives a NOP at this edge.
- `stall_count`  out  CNT_W  saturating count of stall cycles.

## Operation
- Decode (per instruction): R-type (op 0x00) writes rd, reads rs,rt; lw (0x23) writes rt, reads rs, is_load; sw (0x2B) reads rs,rt; beq/bne (0x04/0x05) read rs,rt, is_branch; addi/addiu/slti/sltiu/andi/ori (0x08–0x0D) write rt, read rs; lui (0x0F) writes rt; j (0x02) and other opcodes read/write nothing.
- Scoreboard slot fields: valid, dest[4:0], is_load. A slot counts as a writer only if valid and dest != 0.
- Data hazard (`FORWARD`=0): `instr_valid`, and some read source equals the dest of a writer in any slot 0..DEPTH-1. Register $0 never matches.
- Data hazard (`FORWARD`=1): as above, restricted to slot 0 with is_load=1.
- States: RUN, BRANCH_HOLD (counter `bcnt` nonzero).
- RUN: `stall` = data hazard; `issue` = instr_valid & !stall; `bubble` = !issue.
- BRANCH_HOLD: `stall`=1, `issue`=0, `bubble`=1. The instruction in ID is not evaluated.
- Each edge: scoreboard shifts (slot k to slot k+1, oldest dropped). Slot 0 loads the decoded issued instruction, or an invalid entry on a bubble.
- A branch issuing in RUN loads `bcnt` = BRANCH_SLOTS. `bcnt` decrements each cycle in BRANCH_HOLD, and the block returns to RUN when `bcnt` reaches 0. With BRANCH_SLOTS=0 the block never leaves RUN.
- A branch with a data hazard stalls in RUN first; the hold starts only once the branch issues.
- `stall_count` increments on every cycle where `stall`=1 and saturates at all-ones. `instr_valid`=0 is not a stall.

## Timing
- `stall`, `issue` and `bubble` are combinational from `instr`, `instr_valid` and registered state, in the same cycle. Scoreboard and `bcnt` update on the rising edge.
- A RAW conflict with the producer in slot k (FORWARD=0) stalls for DEPTH-k cycles. Example: back-to-back dependent instructions with DEPTH=3 give 3 stall cycles.
- Load-use with FORWARD=1 gives exactly 1 stall cycle.
- Reset (asynchronous, at any point, including mid-hold or mid-stall): all slots invalid, `bcnt`=0, state RUN, `stall_count`=0.
  - Outputs during reset: `stall`=0, `bubble`=!instr_valid, `issue`=instr_valid.
- The first edge after reset deassertion behaves as RUN with an empty scoreboard.

## Structure
- Shared package `hazard_pkg`: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI..OP_ORI, OP_LUI, OP_J) and the scoreboard-entry field layout.
- Sub-module `hazard_decode`: purely combinational. Takes instr and produces rs_used, rt_used, writes, dest, is_load, is_branch. It is instantiated once at the top, which holds the scoreboard, `bcnt` and counter.

## Test plan
- DEPTH=3, FORWARD=0: `add $3,$1,$2` then `sub $4,$3,$5`. Expect `stall`=1 for 3 cycles with `bubble` each cycle, `sub` issues on cycle 4, `stall_count`=3.
- FORWARD=1: `lw $8,0($9)` then `add $10,$8,$8`. Expect exactly 1 stall cycle. Repeat with `add $8,...` as the producer: expect 0 stalls.
- Writer to $0 (`add $0,$1,$2`) followed by a reader of $0. Expect 0 stalls.
- BRANCH_SLOTS=2: `beq $1,$2,x` with no hazard issues. Expect `stall`=1, `issue`=0 for 2 cycles, then RUN. With a hazard on $1 from the prior instruction: data stalls first, then the 2 hold cycles.
- Assert `reset` during BRANCH_HOLD with `bcnt`=1 and during a data stall. Expect all outputs at reset values immediately, and no stall on the next instruction afterwards.
- CNT_W=4: force 20 stall cycles. Expect `stall_count` to saturate at 15.
